// File: rtl/rx_write_cmd_gen.sv
// rx_write_cmd_gen
// ----------------
// Turns one parsed RDMA write header plus its payload stream into a single
// AXI DataMover S2MM command, then forwards the payload to the DataMover.
// Packets with an unsupported opcode or an illegal length are consumed and
// discarded without issuing a command.
//
// Ports
//   aclk, areset          clock, synchronous active-high reset
//   hdr_*                 parsed header from rx_header_parser (valid/ready)
//   s_axis_*              payload stream in from the parser
//   m_axis_cmd_*          72-bit DataMover S2MM command out
//   m_axis_s2mm_*         payload stream out to the DataMover
//   err_opcode            one-cycle pulse: opcode unsupported, packet dropped
//   err_length            one-cycle pulse: illegal length or byte-count mismatch
//   pkt_done              one-cycle pulse at the end of every packet
//   bytes_written         running (wrapping) count of bytes sent to S2MM
module rx_write_cmd_gen #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int C_AXIS_TKEEP_WIDTH = 4,
    parameter int BTT_WIDTH          = 23
) (
    input  logic                          aclk,
    input  logic                          areset,

    input  logic                          hdr_valid,
    output logic                          hdr_ready,
    input  logic [7:0]                    hdr_opcode,
    input  logic [31:0]                   hdr_remote_addr,
    input  logic [15:0]                   hdr_fragment_offset,
    input  logic [31:0]                   hdr_length,

    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,

    output logic [71:0]                   m_axis_cmd_tdata,
    output logic                          m_axis_cmd_tvalid,
    input  logic                          m_axis_cmd_tready,

    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_s2mm_tdata,
    output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_s2mm_tkeep,
    output logic                          m_axis_s2mm_tvalid,
    input  logic                          m_axis_s2mm_tready,
    output logic                          m_axis_s2mm_tlast,

    output logic                          err_opcode,
    output logic                          err_length,
    output logic                          pkt_done,
    output logic [31:0]                   bytes_written
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CMD  = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
    localparam logic [2:0] DROP = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]  state;
    logic [31:0] length_q;
    logic [31:0] pkt_bytes;
    logic [3:0]  tag;
    logic        op_legal;
    logic        len_bad;
    logic        s_beat;
    logic [31:0] beat_bytes;
    logic [31:0] pkt_bytes_next;
    logic [31:0] cmd_addr;

    // Header legality and the destination address are evaluated on the live
    // header inputs so the decision is ready in the acceptance cycle. The
    // address add deliberately drops the carry so it wraps at 4 GiB.
    // A length is too large when any bit at or above BTT_WIDTH is set.
    assign op_legal = (hdr_opcode == 8'h01) || (hdr_opcode == 8'h0A);
    assign len_bad  = (hdr_length == 32'd0) || ((hdr_length >> BTT_WIDTH) != 32'd0);
    assign cmd_addr = hdr_remote_addr + {16'd0, hdr_fragment_offset};

    // Handshake outputs are pure functions of the state so nothing in the
    // payload path adds a register stage. In DATA the payload is a straight
    // wire to the DataMover; in DROP every beat is swallowed; in every other
    // state the parser is held off so no beat is lost or duplicated.
    assign hdr_ready          = (state == IDLE);
    assign m_axis_cmd_tvalid  = (state == CMD);
    assign pkt_done           = (state == DONE);
    assign s_axis_tready      = (state == DATA) ? m_axis_s2mm_tready : (state == DROP);
    assign m_axis_s2mm_tvalid = (state == DATA) && s_axis_tvalid;
    assign m_axis_s2mm_tdata  = s_axis_tdata;
    assign m_axis_s2mm_tkeep  = s_axis_tkeep;
    assign m_axis_s2mm_tlast  = s_axis_tlast;

    assign s_beat         = s_axis_tvalid && s_axis_tready;
    assign beat_bytes     = 32'($countones(s_axis_tkeep));
    assign pkt_bytes_next = pkt_bytes + beat_bytes;

    // Main packet FSM. Error flags default low every cycle so any set below
    // produces exactly a one-cycle pulse in the cycle after the event.
    // The command word is captured once at header acceptance and then held
    // unchanged for as long as the DataMover stalls it.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state            <= IDLE;
            length_q         <= 32'd0;
            pkt_bytes        <= 32'd0;
            bytes_written    <= 32'd0;
            tag              <= 4'd0;
            m_axis_cmd_tdata <= 72'd0;
            err_opcode       <= 1'b0;
            err_length       <= 1'b0;
        end else begin
            err_opcode <= 1'b0;
            err_length <= 1'b0;
            case (state)
                IDLE: begin
                    if (hdr_valid) begin
                        length_q   <= hdr_length;
                        err_opcode <= !op_legal;
                        err_length <= len_bad;
                        if (!op_legal || len_bad) begin
                            state <= DROP;
                        end else begin
                            m_axis_cmd_tdata <= {4'd0, tag, cmd_addr, 1'b0, 1'b1,
                                                 6'd0, 1'b1, hdr_length[22:0]};
                            state <= CMD;
                        end
                    end
                end
                CMD: begin
                    if (m_axis_cmd_tready) begin
                        tag   <= tag + 4'd1;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (s_beat) begin
                        pkt_bytes     <= pkt_bytes_next;
                        bytes_written <= bytes_written + beat_bytes;
                        if (s_axis_tlast) begin
                            err_length <= (pkt_bytes_next != length_q);
                            state      <= DONE;
                        end
                    end
                end
                DROP: begin
                    if (s_beat && s_axis_tlast) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    pkt_bytes <= 32'd0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_write_cmd_gen.sv
// tb_rx_write_cmd_gen
// -------------------
// Directed self-checking bench for rx_write_cmd_gen. Each test task drives
// one scenario and compares the monitored results against hand-computed
// values.
module tb_rx_write_cmd_gen;

    logic        aclk;
    logic        areset;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [7:0]  hdr_opcode;
    logic [31:0] hdr_remote_addr;
    logic [15:0] hdr_fragment_offset;
    logic [31:0] hdr_length;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [71:0] m_axis_cmd_tdata;
    logic        m_axis_cmd_tvalid;
    logic        m_axis_cmd_tready;
    logic [31:0] m_axis_s2mm_tdata;
    logic [3:0]  m_axis_s2mm_tkeep;
    logic        m_axis_s2mm_tvalid;
    logic        m_axis_s2mm_tready;
    logic        m_axis_s2mm_tlast;
    logic        err_opcode;
    logic        err_length;
    logic        pkt_done;
    logic [31:0] bytes_written;

    int vectors    = 0;
    int miscompares = 0;

    // Monitor state, cleared at the start of each scenario.
    int          cmd_cnt;
    logic [71:0] last_cmd;
    logic [31:0] out_q[$];
    int          in_cnt;
    int          err_op_cnt;
    int          err_len_cnt;
    int          done_cnt;

    rx_write_cmd_gen dut (
        .aclk                (aclk),
        .areset              (areset),
        .hdr_valid           (hdr_valid),
        .hdr_ready           (hdr_ready),
        .hdr_opcode          (hdr_opcode),
        .hdr_remote_addr     (hdr_remote_addr),
        .hdr_fragment_offset (hdr_fragment_offset),
        .hdr_length          (hdr_length),
        .s_axis_tdata        (s_axis_tdata),
        .s_axis_tkeep        (s_axis_tkeep),
        .s_axis_tvalid       (s_axis_tvalid),
        .s_axis_tready       (s_axis_tready),
        .s_axis_tlast        (s_axis_tlast),
        .m_axis_cmd_tdata    (m_axis_cmd_tdata),
        .m_axis_cmd_tvalid   (m_axis_cmd_tvalid),
        .m_axis_cmd_tready   (m_axis_cmd_tready),
        .m_axis_s2mm_tdata   (m_axis_s2mm_tdata),
        .m_axis_s2mm_tkeep   (m_axis_s2mm_tkeep),
        .m_axis_s2mm_tvalid  (m_axis_s2mm_tvalid),
        .m_axis_s2mm_tready  (m_axis_s2mm_tready),
        .m_axis_s2mm_tlast   (m_axis_s2mm_tlast),
        .err_opcode          (err_opcode),
        .err_length          (err_length),
        .pkt_done            (pkt_done),
        .bytes_written       (bytes_written)
    );

    // 100 MHz clock.
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Inputs change 2 ns after the rising edge, so the falling edge sees the
    // exact values the next rising edge will act on. Handshakes, pulses and
    // forwarded data are logged here.
    always @(negedge aclk) begin
        if (m_axis_cmd_tvalid && m_axis_cmd_tready) begin
            cmd_cnt  = cmd_cnt + 1;
            last_cmd = m_axis_cmd_tdata;
        end
        if (m_axis_s2mm_tvalid && m_axis_s2mm_tready)
            out_q.push_back(m_axis_s2mm_tdata);
        if (s_axis_tvalid && s_axis_tready)
            in_cnt = in_cnt + 1;
        if (err_opcode) err_op_cnt  = err_op_cnt + 1;
        if (err_length) err_len_cnt = err_len_cnt + 1;
        if (pkt_done)   done_cnt    = done_cnt + 1;
    end

    task automatic clear_mon();
        cmd_cnt     = 0;
        last_cmd    = 72'd0;
        out_q.delete();
        in_cnt      = 0;
        err_op_cnt  = 0;
        err_len_cnt = 0;
        done_cnt    = 0;
    endtask

    // Presents one header followed by nbeats payload beats whose data is
    // base+i. With toggle set, the DataMover ready flips every cycle. With
    // abort_at >= 0 the task returns right after that many beats were
    // accepted, leaving the stream mid-packet.
    task automatic send_pkt(input logic [7:0] op, input logic [31:0] addr,
                            input logic [15:0] off, input logic [31:0] len,
                            input int nbeats, input logic [3:0] lastkeep,
                            input logic [31:0] base, input bit toggle,
                            input int abort_at);
        int acc;
        int guard;
        acc   = 0;
        guard = 0;
        @(posedge aclk); #2;
        hdr_valid           = 1'b1;
        hdr_opcode          = op;
        hdr_remote_addr     = addr;
        hdr_fragment_offset = off;
        hdr_length          = len;
        #1;
        while (!hdr_ready && guard < 100) begin
            @(posedge aclk); #3;
            guard++;
        end
        if (!hdr_ready) begin
            vectors++; miscompares++;
            $display("[TB] FAIL hdr_accept: hdr_ready stuck at %0b, required 1", hdr_ready);
        end
        @(posedge aclk); #2;
        hdr_valid = 1'b0;
        guard     = 0;
        while (acc < nbeats && guard < 4000) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + 32'(acc);
            s_axis_tkeep  = (acc == nbeats - 1) ? lastkeep : 4'hF;
            s_axis_tlast  = (acc == nbeats - 1);
            m_axis_s2mm_tready = toggle ? ~m_axis_s2mm_tready : 1'b1;
            #1;
            if (s_axis_tready) acc++;
            @(posedge aclk); #2;
            guard++;
            if (abort_at >= 0 && acc == abort_at) return;
        end
        s_axis_tvalid      = 1'b0;
        s_axis_tlast       = 1'b0;
        m_axis_s2mm_tready = 1'b1;
        if (acc < nbeats) begin
            vectors++; miscompares++;
            $display("[TB] FAIL beat_timeout: %0d beats accepted, required %0d", acc, nbeats);
        end
        repeat (4) @(posedge aclk);
        #2;
    endtask

    task automatic test_reset();
        areset             = 1'b1;
        s_axis_tvalid      = 1'b1;
        m_axis_s2mm_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #2;
        areset = 1'b0;
        #1;
        vectors++; if (hdr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_hdr_ready: got %b required 1", hdr_ready); end
        vectors++; if (m_axis_cmd_tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_cmd_tvalid: got %b required 0", m_axis_cmd_tvalid); end
        vectors++; if (m_axis_s2mm_tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_s2mm_tvalid: got %b required 0", m_axis_s2mm_tvalid); end
        vectors++; if (s_axis_tready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_s_tready: got %b required 0", s_axis_tready); end
        vectors++; if ({err_opcode, err_length, pkt_done} !== 3'b000) begin miscompares++; $display("[TB] FAIL rst_pulses: got %b required 000", {err_opcode, err_length, pkt_done}); end
        vectors++; if (bytes_written !== 32'd0) begin miscompares++; $display("[TB] FAIL rst_bytes: got %0d required 0", bytes_written); end
        vectors++; if (m_axis_cmd_tdata !== 72'd0) begin miscompares++; $display("[TB] FAIL rst_cmd_tdata: got %h required 0", m_axis_cmd_tdata); end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_basic();
        bit bad;
        clear_mon();
        send_pkt(8'h01, 32'h4000_0000, 16'h0000, 32'd256, 64, 4'hF, 32'h1000_0000, 1'b0, -1);
        bad = 1'b0;
        foreach (out_q[i]) if (out_q[i] !== 32'h1000_0000 + 32'(i)) bad = 1'b1;
        vectors++; if (cmd_cnt !== 1) begin miscompares++; $display("[TB] FAIL basic_cmd_cnt: got %0d required 1", cmd_cnt); end
        vectors++; if (last_cmd !== 72'h00_4000_0000_4080_0100) begin miscompares++; $display("[TB] FAIL basic_cmd: got %h required 00400000004080 0100", last_cmd); end
        vectors++; if (out_q.size() !== 64) begin miscompares++; $display("[TB] FAIL basic_beats: got %0d required 64", out_q.size()); end
        vectors++; if (bad) begin miscompares++; $display("[TB] FAIL basic_order: got corrupted order required base+i"); end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("[TB] FAIL basic_done: got %0d required 1", done_cnt); end
        vectors++; if (bytes_written !== 32'd256) begin miscompares++; $display("[TB] FAIL basic_bytes: got %0d required 256", bytes_written); end
        vectors++; if (err_op_cnt + err_len_cnt !== 0) begin miscompares++; $display("[TB] FAIL basic_errors: got %0d required 0", err_op_cnt + err_len_cnt); end
    endtask

    task automatic test_backpressure();
        bit bad;
        clear_mon();
        send_pkt(8'h01, 32'h4000_0000, 16'h1000, 32'd512, 128, 4'hF, 32'h2000_0000, 1'b1, -1);
        bad = 1'b0;
        foreach (out_q[i]) if (out_q[i] !== 32'h2000_0000 + 32'(i)) bad = 1'b1;
        vectors++; if (last_cmd !== 72'h01_4000_1000_4080_0200) begin miscompares++; $display("[TB] FAIL bp_cmd: got %h required 014000100040800200", last_cmd); end
        vectors++; if (out_q.size() !== 128) begin miscompares++; $display("[TB] FAIL bp_beats: got %0d required 128", out_q.size()); end
        vectors++; if (bad) begin miscompares++; $display("[TB] FAIL bp_order: got corrupted order required base+i"); end
        vectors++; if (bytes_written !== 32'd768) begin miscompares++; $display("[TB] FAIL bp_bytes: got %0d required 768", bytes_written); end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("[TB] FAIL bp_done: got %0d required 1", done_cnt); end
    endtask

    task automatic test_addr_wrap();
        clear_mon();
        send_pkt(8'h0A, 32'hFFFF_F000, 16'h3000, 32'd128, 32, 4'hF, 32'h3000_0000, 1'b0, -1);
        vectors++; if (last_cmd !== 72'h02_0000_2000_4080_0080) begin miscompares++; $display("[TB] FAIL wrap_cmd: got %h required 020000200040800080", last_cmd); end
        vectors++; if (out_q.size() !== 32) begin miscompares++; $display("[TB] FAIL wrap_beats: got %0d required 32", out_q.size()); end
        vectors++; if (err_op_cnt + err_len_cnt !== 0) begin miscompares++; $display("[TB] FAIL wrap_errors: got %0d required 0", err_op_cnt + err_len_cnt); end
        vectors++; if (bytes_written !== 32'd896) begin miscompares++; $display("[TB] FAIL wrap_bytes: got %0d required 896", bytes_written); end
    endtask

    task automatic test_bad_opcode();
        clear_mon();
        send_pkt(8'h05, 32'h4000_0000, 16'h0000, 32'd64, 16, 4'hF, 32'h4000_0000, 1'b0, -1);
        vectors++; if (err_op_cnt !== 1) begin miscompares++; $display("[TB] FAIL badop_pulse: got %0d required 1", err_op_cnt); end
        vectors++; if (cmd_cnt !== 0) begin miscompares++; $display("[TB] FAIL badop_cmd: got %0d required 0", cmd_cnt); end
        vectors++; if (out_q.size() !== 0) begin miscompares++; $display("[TB] FAIL badop_s2mm: got %0d required 0", out_q.size()); end
        vectors++; if (in_cnt !== 16) begin miscompares++; $display("[TB] FAIL badop_consumed: got %0d required 16", in_cnt); end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("[TB] FAIL badop_done: got %0d required 1", done_cnt); end
        vectors++; if (bytes_written !== 32'd896) begin miscompares++; $display("[TB] FAIL badop_bytes: got %0d required 896", bytes_written); end
    endtask

    task automatic test_length_mismatch();
        clear_mon();
        send_pkt(8'h01, 32'h0000_5000, 16'h0000, 32'd128, 31, 4'h3, 32'h5000_0000, 1'b0, -1);
        vectors++; if (err_len_cnt !== 1) begin miscompares++; $display("[TB] FAIL mism_pulse: got %0d required 1", err_len_cnt); end
        vectors++; if (last_cmd !== 72'h03_0000_5000_4080_0080) begin miscompares++; $display("[TB] FAIL mism_cmd: got %h required 030000500040800080", last_cmd); end
        vectors++; if (bytes_written !== 32'd1018) begin miscompares++; $display("[TB] FAIL mism_bytes: got %0d required 1018", bytes_written); end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("[TB] FAIL mism_done: got %0d required 1", done_cnt); end
        clear_mon();
        send_pkt(8'h01, 32'h0000_0010, 16'h0004, 32'd8, 2, 4'hF, 32'h6000_0000, 1'b0, -1);
        vectors++; if (last_cmd !== 72'h04_0000_0014_4080_0008) begin miscompares++; $display("[TB] FAIL after_cmd: got %h required 040000001440800008", last_cmd); end
        vectors++; if (err_op_cnt + err_len_cnt !== 0) begin miscompares++; $display("[TB] FAIL after_errors: got %0d required 0", err_op_cnt + err_len_cnt); end
        vectors++; if (bytes_written !== 32'd1026) begin miscompares++; $display("[TB] FAIL after_bytes: got %0d required 1026", bytes_written); end
    endtask

    task automatic test_illegal_length();
        clear_mon();
        send_pkt(8'h01, 32'h0000_7000, 16'h0000, 32'd0, 1, 4'hF, 32'h7000_0000, 1'b0, -1);
        send_pkt(8'h0A, 32'h0000_7000, 16'h0000, 32'h0080_0000, 1, 4'hF, 32'h7100_0000, 1'b0, -1);
        vectors++; if (err_len_cnt !== 2) begin miscompares++; $display("[TB] FAIL illen_pulses: got %0d required 2", err_len_cnt); end
        vectors++; if (err_op_cnt !== 0) begin miscompares++; $display("[TB] FAIL illen_op: got %0d required 0", err_op_cnt); end
        vectors++; if (cmd_cnt !== 0) begin miscompares++; $display("[TB] FAIL illen_cmd: got %0d required 0", cmd_cnt); end
        vectors++; if (in_cnt !== 2) begin miscompares++; $display("[TB] FAIL illen_consumed: got %0d required 2", in_cnt); end
        vectors++; if (done_cnt !== 2) begin miscompares++; $display("[TB] FAIL illen_done: got %0d required 2", done_cnt); end
        vectors++; if (bytes_written !== 32'd1026) begin miscompares++; $display("[TB] FAIL illen_bytes: got %0d required 1026", bytes_written); end
    endtask

    task automatic test_cmd_stall();
        clear_mon();
        m_axis_cmd_tready = 1'b0;
        @(posedge aclk); #2;
        hdr_valid           = 1'b1;
        hdr_opcode          = 8'h0A;
        hdr_remote_addr     = 32'h0000_2000;
        hdr_fragment_offset = 16'h0010;
        hdr_length          = 32'd4;
        @(posedge aclk); #2;
        hdr_opcode    = 8'h01;
        hdr_length    = 32'd64;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hCAFE_0001;
        s_axis_tkeep  = 4'hF;
        s_axis_tlast  = 1'b1;
        repeat (3) @(posedge aclk);
        #3;
        vectors++; if (m_axis_cmd_tvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_tvalid: got %b required 1", m_axis_cmd_tvalid); end
        vectors++; if (m_axis_cmd_tdata !== 72'h05_0000_2010_4080_0004) begin miscompares++; $display("[TB] FAIL stall_cmd: got %h required 050000201040800004", m_axis_cmd_tdata); end
        vectors++; if (hdr_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_hdr_ready: got %b required 0", hdr_ready); end
        vectors++; if (s_axis_tready !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_s_tready: got %b required 0", s_axis_tready); end
        hdr_valid         = 1'b0;
        m_axis_cmd_tready = 1'b1;
        repeat (6) @(posedge aclk);
        #2;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(posedge aclk);
        #2;
        vectors++; if (cmd_cnt !== 1) begin miscompares++; $display("[TB] FAIL stall_cmd_cnt: got %0d required 1", cmd_cnt); end
        vectors++; if (out_q.size() !== 1 || out_q[0] !== 32'hCAFE_0001) begin miscompares++; $display("[TB] FAIL stall_beat: got %0d beats required 1 of cafe0001", out_q.size()); end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("[TB] FAIL stall_done: got %0d required 1", done_cnt); end
        vectors++; if (bytes_written !== 32'd1030) begin miscompares++; $display("[TB] FAIL stall_bytes: got %0d required 1030", bytes_written); end
    endtask

    task automatic test_reset_midpacket();
        clear_mon();
        send_pkt(8'h01, 32'h0000_9000, 16'h0000, 32'd256, 64, 4'hF, 32'h9000_0000, 1'b0, 10);
        areset = 1'b1;
        @(posedge aclk); #3;
        vectors++; if (m_axis_s2mm_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_stream: got tvalid %b tready %b required 0 0", m_axis_s2mm_tvalid, s_axis_tready); end
        vectors++; if (bytes_written !== 32'd0) begin miscompares++; $display("[TB] FAIL mid_bytes: got %0d required 0", bytes_written); end
        vectors++; if (hdr_ready !== 1'b1 || m_axis_cmd_tdata !== 72'd0) begin miscompares++; $display("[TB] FAIL mid_state: got hdr_ready %b cmd %h required 1 0", hdr_ready, m_axis_cmd_tdata); end
        areset        = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        clear_mon();
        send_pkt(8'h01, 32'h0000_0100, 16'h0000, 32'd4, 1, 4'hF, 32'hA000_0000, 1'b0, -1);
        vectors++; if (last_cmd !== 72'h00_0000_0100_4080_0004) begin miscompares++; $display("[TB] FAIL mid_next_cmd: got %h required 000000010040800004", last_cmd); end
        vectors++; if (bytes_written !== 32'd4) begin miscompares++; $display("[TB] FAIL mid_next_bytes: got %0d required 4", bytes_written); end
    endtask

    // Scenario sequence; the byte counter and tag carry across scenarios so
    // the expected values above accumulate in this order.
    initial begin
        areset              = 1'b1;
        hdr_valid           = 1'b0;
        hdr_opcode          = 8'h00;
        hdr_remote_addr     = 32'd0;
        hdr_fragment_offset = 16'd0;
        hdr_length          = 32'd0;
        s_axis_tdata        = 32'd0;
        s_axis_tkeep        = 4'h0;
        s_axis_tvalid       = 1'b0;
        s_axis_tlast        = 1'b0;
        m_axis_cmd_tready   = 1'b1;
        m_axis_s2mm_tready  = 1'b1;
        clear_mon();
        test_reset();
        test_basic();
        test_backpressure();
        test_addr_wrap();
        test_bad_opcode();
        test_length_mismatch();
        test_illegal_length();
        test_cmd_stall();
        test_reset_midpacket();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
